uart_debug_tx: RTL and testbench

UART_DEBUG_TX -- requirements
Module: uart_debug_tx

---
 rtl/uart_debug_pkg.sv | 30 +++
 rtl/uart_debug_fifo.sv | 65 ++++++
 rtl/uart_debug_tx.sv | 135 +++++++++++++
 tb/tb_uart_debug_tx.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_debug_pkg.sv
// uart_debug_pkg
// Shared definitions for the debug UART transmitter: FSM state encoding,
// frame constants and the parity helper.
// Build option: define UART_DEBUG_TX_PARITY_EN for 8E1 framing (even parity
// bit between the last data bit and the stop bit). Left undefined the link is
// 8N1 and the PARITY state does not exist.
package uart_debug_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Encoding is fixed so the debug state output reads the same in every build.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_DEBUG_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

`ifdef UART_DEBUG_TX_PARITY_EN
  // Even parity: the transmitted bit makes the total count of ones even.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction
`endif

endpackage

// File: rtl/uart_debug_fifo.sv
// uart_debug_fifo
// Show-ahead byte FIFO feeding the UART serializer. rd_data always presents
// the head entry; rd_en pops it. Writes while full and reads while empty are
// ignored, so the caller may hold wr_en without checking full.
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   wr_en, wr_data     push request and data
//   rd_en, rd_data     pop request and head-of-queue data
//   count              entries stored (one bit wider than the pointers)
//   full, empty        derived from the registered count
module uart_debug_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             wr_ok, rd_ok;

  // full comes from the registered count: a pop does not open a slot for a
  // write in the same cycle, which keeps ready free of any path from the FSM.
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr_q];
  assign count   = count_q;

  // Storage is deliberately not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_debug_tx.sv
// uart_debug_tx
// Buffered UART transmitter for debug output: bytes are queued in a small
// FIFO and shifted out LSB first as 8N1 frames (8E1 when the build defines
// UART_DEBUG_TX_PARITY_EN).
// Handshake: a byte is taken on every rising clk edge where i_tx_dv and
// o_tx_ready are both high; i_tx_byte is sampled on that edge. When
// o_tx_ready is low the offer is ignored and the sender must keep or repeat
// it. o_tx_ready depends only on registered state.
// Ports:
//   clk, resetn     clock, asynchronous active-low reset (aborts the frame
//                   and flushes the queue)
//   i_tx_dv         byte valid
//   i_tx_byte       payload byte
//   o_tx_ready      FIFO not full
//   o_tx_serial     UART line, idle high
//   o_tx_active     high while a frame is on the line
//   o_tx_done       one-cycle pulse on the last cycle of each stop bit
//   o_fifo_count    bytes waiting in the FIFO
//   o_dbg_state     current FSM state for monitors
module uart_debug_tx
  import uart_debug_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          i_tx_dv,
  input  logic [7:0]                    i_tx_byte,
  output logic                          o_tx_ready,
  output logic                          o_tx_serial,
  output logic                          o_tx_active,
  output logic                          o_tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output state_t                        o_dbg_state
);

  localparam int              TW         = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      BIT_LAST   = 3'(UART_DATA_BITS - 1);

  state_t     state_q, state_d;
  logic [TW-1:0] timer_q;
  logic [2:0] bit_idx_q;
  logic [7:0] shift_q;
  logic       timer_last;
  logic       fifo_rd_en, fifo_full, fifo_empty;
  logic [7:0] fifo_rd_data;

  assign timer_last  = (timer_q == TIMER_LAST);
  // The head byte is popped in the single IDLE cycle; START follows next edge,
  // so the start bit appears two cycles after the byte is presented.
  assign fifo_rd_en  = (state_q == IDLE) && !fifo_empty;
  assign o_tx_ready  = !fifo_full;
  assign o_dbg_state = state_q;

  uart_debug_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (i_tx_dv),
    .wr_data (i_tx_byte),
    .rd_en   (fifo_rd_en),
    .rd_data (fifo_rd_data),
    .count   (o_fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!fifo_empty) state_d = START;
      START: if (timer_last)  state_d = DATA;
      DATA: begin
        if (timer_last && (bit_idx_q == BIT_LAST)) begin
`ifdef UART_DEBUG_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_DEBUG_TX_PARITY_EN
      PARITY: if (timer_last) state_d = STOP;
`endif
      STOP:  if (timer_last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bit timer, data bit index and frame byte. The timer idles at zero so each
  // frame starts with a full-length start bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      if ((state_q == IDLE) || timer_last) timer_q <= '0;
      else                                 timer_q <= timer_q + TW'(1);
      if ((state_q == DATA) && timer_last)
        bit_idx_q <= (bit_idx_q == BIT_LAST) ? 3'd0 : bit_idx_q + 3'd1;
      if (fifo_rd_en) shift_q <= fifo_rd_data;
    end
  end

  // Outputs are decoded from registered state only, so reset forces the line
  // high without waiting for a clock.
  always_comb begin
    o_tx_serial = UART_IDLE_LEVEL;
    o_tx_active = 1'b1;
    o_tx_done   = 1'b0;
    case (state_q)
      IDLE:   o_tx_active = 1'b0;
      START:  o_tx_serial = ~UART_IDLE_LEVEL;
      DATA:   o_tx_serial = shift_q[bit_idx_q];
`ifdef UART_DEBUG_TX_PARITY_EN
      PARITY: o_tx_serial = even_parity(shift_q);
`endif
      STOP:   o_tx_done   = timer_last;
      default: o_tx_active = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_uart_debug_tx.sv
// tb_uart_debug_tx
// Self-checking bench for uart_debug_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A reference model describes the link in terms of whole frames: a queue of
// waiting bytes, and for the frame on the line only the byte and the cycle
// offset into the frame. Line level, active, done, ready and count are all
// derived from those with plain arithmetic.
module tb_uart_debug_tx;
  import uart_debug_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int BW    = 4 + CW;
`ifdef UART_DEBUG_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_LEN = FRAME_BITS * CPB;
  // {ready, serial, active, done, count} while in reset
  localparam logic [BW-1:0] RST_EXP = {1'b1, 1'b1, 1'b0, 1'b0, {CW{1'b0}}};

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          resetn;
  logic          i_tx_dv = 1'b0;
  logic [7:0]    i_tx_byte = 8'h00;
  logic          o_tx_ready, o_tx_serial, o_tx_active, o_tx_done;
  logic [CW-1:0] o_fifo_count;
  state_t        dbg_state;

  always #5 clk = ~clk;

  uart_debug_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .i_tx_dv      (i_tx_dv),
    .i_tx_byte    (i_tx_byte),
    .o_tx_ready   (o_tx_ready),
    .o_tx_serial  (o_tx_serial),
    .o_tx_active  (o_tx_active),
    .o_tx_done    (o_tx_done),
    .o_fifo_count (o_fifo_count),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];     // bytes accepted and still waiting in the FIFO
  bit         m_busy = 0;   // a frame is on the line
  int         m_cyc  = 0;   // cycle offset into that frame
  logic [7:0] m_byte = 8'h00;
  bit         m_acc  = 0;   // last edge accepted a byte
  int         m_frames = 0; // frames completed
  int         dut_done = 0; // o_tx_done pulses observed

  // Advance one clock: the model sees the same inputs the DUT samples.
  task automatic cycle();
    bit pop;
    @(posedge clk);
    if (!resetn) begin
      exp_q.delete();
      m_busy = 0;
      m_cyc  = 0;
      m_acc  = 0;
    end else begin
      m_acc = i_tx_dv && (exp_q.size() < DEPTH);
      pop   = !m_busy && (exp_q.size() > 0);
      if (m_busy) begin
        if (m_cyc == FRAME_LEN - 1) begin
          m_busy = 0;
          m_frames++;
        end else m_cyc++;
      end
      if (pop) begin
        m_byte = exp_q.pop_front();
        m_busy = 1;
        m_cyc  = 0;
      end
      if (m_acc) exp_q.push_back(i_tx_byte);
    end
    @(negedge clk);
    if (o_tx_done === 1'b1) dut_done++;
  endtask

  function automatic logic [BW-1:0] model_out();
    logic line;
    int   idx;
    line = 1'b1;
    if (m_busy) begin
      idx = m_cyc / CPB;
      if (idx == 0)                           line = 1'b0;
      else if (idx <= 8)                      line = m_byte[idx-1];
      else if (FRAME_BITS == 11 && idx == 9)  line = ^m_byte;
      else                                    line = 1'b1;
    end
    return {exp_q.size() < DEPTH, line, m_busy,
            m_busy && (m_cyc == FRAME_LEN - 1), CW'(exp_q.size())};
  endfunction

  function automatic logic [BW-1:0] observed();
    return {o_tx_ready, o_tx_serial, o_tx_active, o_tx_done, o_fifo_count};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #1;
    n_vec++;
    if (observed() !== RST_EXP) begin
      n_err++;
      $display("FAIL reset_async: got %b expected %b", observed(), RST_EXP);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_vec++;
      if (observed() !== RST_EXP || dbg_state !== IDLE) begin
        n_err++;
        $display("FAIL reset_hold: got %b state %0d expected %b state 0",
                 observed(), dbg_state, RST_EXP);
      end
    end
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_vec++;
      if (observed() !== model_out()) begin
        n_err++;
        $display("FAIL reset_release: got %b expected %b", observed(), model_out());
      end
    end
  endtask

  task automatic test_single_a5();
    logic line_q[$];
    logic exp_bits[$];
    int   first_low = -1;
    m_frames = 0; dut_done = 0;
    exp_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
`ifdef UART_DEBUG_TX_PARITY_EN
    exp_bits.push_back(1'b0);
`endif
    exp_bits.push_back(1'b1);
    i_tx_dv = 1'b1; i_tx_byte = 8'hA5;
    cycle();
    i_tx_dv = 1'b0;
    for (int t = 0; t < FRAME_LEN + 4; t++) begin
      // t counts cycles after the accept cycle; t=0 is the IDLE pop cycle
      n_vec++;
      if (observed() !== model_out()) begin
        n_err++;
        $display("FAIL single_a5 t=%0d: got %b expected %b", t, observed(), model_out());
      end
      line_q.push_back(o_tx_serial);
      if (o_tx_serial === 1'b0 && first_low < 0) first_low = t;
      cycle();
    end
    n_vec++;
    if (first_low != 1) begin
      n_err++;
      $display("FAIL single_a5_latency: start edge at %0d expected 1", first_low);
    end
    for (int k = 0; k < FRAME_BITS; k++) begin
      int s;
      s = first_low + k * CPB + CPB / 2;
      if (first_low >= 0 && s < line_q.size()) begin
        n_vec++;
        if (line_q[s] !== exp_bits[k]) begin
          n_err++;
          $display("FAIL single_a5_bit%0d: got %b expected %b", k, line_q[s], exp_bits[k]);
        end
      end
    end
    n_vec++;
    if (dut_done != 1) begin
      n_err++;
      $display("FAIL single_a5_done: got %0d pulses expected 1", dut_done);
    end
  endtask

  task automatic test_back_to_back();
    bit saw_full = 0;
    m_frames = 0; dut_done = 0;
    for (int b = 1; b <= 5; b++) begin
      i_tx_dv = 1'b1; i_tx_byte = 8'(b);
      cycle();
      n_vec++;
      if (observed() !== model_out()) begin
        n_err++;
        $display("FAIL b2b_write%0d: got %b expected %b", b, observed(), model_out());
      end
      if (o_tx_ready === 1'b0) saw_full = 1;
    end
    i_tx_dv = 1'b0;
    for (int t = 0; t < 6 * (FRAME_LEN + 1) + 4; t++) begin
      cycle();
      n_vec++;
      if (observed() !== model_out()) begin
        n_err++;
        $display("FAIL b2b t=%0d: got %b expected %b", t, observed(), model_out());
      end
    end
    n_vec++;
    if (!saw_full || dut_done != m_frames || o_fifo_count !== '0) begin
      n_err++;
      $display("FAIL b2b_summary: full_seen %0d frames %0d count %0d expected 1 %0d 0",
               saw_full, dut_done, o_fifo_count, m_frames);
    end
  endtask

  task automatic test_full_hold();
    int t;
    m_frames = 0; dut_done = 0;
    // 0x30 goes on the line, the rest overfill the queue (extras dropped)
    for (int b = 0; b < 7; b++) begin
      i_tx_dv = 1'b1; i_tx_byte = 8'h30 + 8'(b);
      cycle();
      n_vec++;
      if (observed() !== model_out()) begin
        n_err++;
        $display("FAIL full_fill%0d: got %b expected %b", b, observed(), model_out());
      end
    end
    // Hold 0x3F across the pop until it is taken exactly once
    i_tx_byte = 8'h3F;
    t = 0;
    do begin
      cycle();
      t++;
      n_vec++;
      if (observed() !== model_out()) begin
        n_err++;
        $display("FAIL full_hold t=%0d: got %b expected %b", t, observed(), model_out());
      end
    end while (!m_acc && t < 2 * FRAME_LEN);
    n_vec++;
    if (!m_acc) begin
      n_err++;
      $display("FAIL full_hold_timeout: byte not taken after %0d cycles", t);
    end
    i_tx_dv = 1'b0;
    for (int k = 0; k < 6 * (FRAME_LEN + 1); k++) begin
      cycle();
      n_vec++;
      if (observed() !== model_out()) begin
        n_err++;
        $display("FAIL full_drain k=%0d: got %b expected %b", k, observed(), model_out());
      end
    end
    n_vec++;
    if (dut_done != m_frames) begin
      n_err++;
      $display("FAIL full_frames: got %0d expected %0d", dut_done, m_frames);
    end
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    m_frames = 0; dut_done = 0;
    for (int b = 0; b < 3; b++) begin
      i_tx_dv = 1'b1;
      i_tx_byte = (b == 0) ? 8'hFF : 8'h55 + 8'(b);
      cycle();
    end
    i_tx_dv = 1'b0;
    // run until DATA bit 3 (frame bit 4) is on the line
    for (int t = 0; t < 3 * FRAME_LEN && !hit; t++) begin
      cycle();
      n_vec++;
      if (observed() !== model_out()) begin
        n_err++;
        $display("FAIL mid_run t=%0d: got %b expected %b", t, observed(), model_out());
      end
      if (m_busy && m_cyc == 4 * CPB + 1) hit = 1;
    end
    n_vec++;
    if (!hit || o_fifo_count !== CW'(2)) begin
      n_err++;
      $display("FAIL mid_setup: reached %0d count %0d expected 1 2", hit, o_fifo_count);
    end
    #2 resetn = 1'b0;
    #1;
    n_vec++;
    if (observed() !== RST_EXP) begin
      n_err++;
      $display("FAIL mid_reset_async: got %b expected %b", observed(), RST_EXP);
    end
    cycle();
    resetn = 1'b1;
    for (int t = 0; t < 2 * FRAME_LEN; t++) begin
      cycle();
      n_vec++;
      if (observed() !== model_out()) begin
        n_err++;
        $display("FAIL mid_after t=%0d: got %b expected %b", t, observed(), model_out());
      end
    end
    n_vec++;
    if (dut_done != 0) begin
      n_err++;
      $display("FAIL mid_no_frames: got %0d done pulses expected 0", dut_done);
    end
  endtask

  task automatic test_parity();
    logic [7:0] pat [2];
    pat[0] = 8'h00; pat[1] = 8'h07;
    for (int p = 0; p < 2; p++) begin
      int   act = 0;
      int   first_low = -1;
      logic pbit = 1'bx;
      logic pexp;
      i_tx_dv = 1'b1; i_tx_byte = pat[p];
      cycle();
      i_tx_dv = 1'b0;
      for (int t = 0; t < FRAME_LEN + 4; t++) begin
        n_vec++;
        if (observed() !== model_out()) begin
          n_err++;
          $display("FAIL parity_%02h t=%0d: got %b expected %b", pat[p], t, observed(), model_out());
        end
        if (o_tx_active === 1'b1) act++;
        if (o_tx_serial === 1'b0 && first_low < 0) first_low = t;
        if (first_low >= 0 && t == first_low + 9 * CPB + CPB / 2) pbit = o_tx_serial;
        cycle();
      end
`ifdef UART_DEBUG_TX_PARITY_EN
      pexp = ^pat[p];
`else
      pexp = 1'b1;   // stop bit follows bit 7 directly
`endif
      n_vec++;
      if (act != FRAME_LEN || pbit !== pexp) begin
        n_err++;
        $display("FAIL parity_%02h_frame: len %0d bit9 %b expected %0d %b",
                 pat[p], act, pbit, FRAME_LEN, pexp);
      end
    end
  endtask

  task automatic test_wrap();
    int idx = 0;
    int t   = 0;
    m_frames = 0; dut_done = 0;
    while (idx < 10 && t < 20 * FRAME_LEN) begin
      i_tx_dv = 1'b1; i_tx_byte = 8'h10 + 8'(idx);
      cycle();
      t++;
      if (m_acc) idx++;
      n_vec++;
      if (observed() !== model_out()) begin
        n_err++;
        $display("FAIL wrap_fill t=%0d: got %b expected %b", t, observed(), model_out());
      end
    end
    i_tx_dv = 1'b0;
    for (int k = 0; k < 6 * (FRAME_LEN + 1); k++) begin
      cycle();
      n_vec++;
      if (observed() !== model_out()) begin
        n_err++;
        $display("FAIL wrap_drain k=%0d: got %b expected %b", k, observed(), model_out());
      end
    end
    n_vec++;
    if (idx != 10 || dut_done != 10 || o_fifo_count !== '0) begin
      n_err++;
      $display("FAIL wrap_summary: sent %0d done %0d count %0d expected 10 10 0",
               idx, dut_done, o_fifo_count);
    end
  endtask

  task automatic test_random();
    m_frames = 0; dut_done = 0;
    for (int t = 0; t < 1500; t++) begin
      i_tx_dv   = ($urandom_range(0, 9) == 0);
      i_tx_byte = 8'($urandom_range(0, 255));
      cycle();
      n_vec++;
      if (observed() !== model_out()) begin
        n_err++;
        $display("FAIL random t=%0d: got %b expected %b", t, observed(), model_out());
      end
    end
    i_tx_dv = 1'b0;
    for (int k = 0; k < 6 * (FRAME_LEN + 1); k++) begin
      cycle();
      n_vec++;
      if (observed() !== model_out()) begin
        n_err++;
        $display("FAIL random_drain k=%0d: got %b expected %b", k, observed(), model_out());
      end
    end
    n_vec++;
    if (dut_done != m_frames) begin
      n_err++;
      $display("FAIL random_frames: got %0d expected %0d", dut_done, m_frames);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_full_hold();
    test_reset_mid();
    test_parity();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
